// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: status codes, instruction codes, and the
// control half of a decode-stage packet.
package y86_pkg;

    localparam logic [1:0] SAOK = 2'd0;
    localparam logic [1:0] SHLT = 2'd1;
    localparam logic [1:0] SADR = 2'd2;
    localparam logic [1:0] SINS = 2'd3;

    localparam logic [3:0] ICODE_HALT = 4'h0;
    localparam logic [3:0] ICODE_NOP  = 4'h1;
    localparam logic [3:0] RNONE      = 4'hF;

    // valC/valP travel next to this struct because their width is a
    // per-instance parameter.
    typedef struct packed {
        logic [1:0] stat;
        logic [3:0] icode;
        logic [3:0] ifun;
        logic [3:0] rA;
        logic [3:0] rB;
    } d_ctrl_t;

    localparam d_ctrl_t BUBBLE_CTRL = '{stat: SAOK, icode: ICODE_NOP, ifun: 4'h0, rA: RNONE, rB: RNONE};

    function automatic d_ctrl_t halt_ctrl(input logic [1:0] stat);
        halt_ctrl = '{stat: stat, icode: ICODE_HALT, ifun: 4'h0, rA: RNONE, rB: RNONE};
    endfunction

endpackage

// File: rtl/d_queue_store.sv
// Circular packet store: DEPTH x W array with head/tail pointers and occupancy.
// The caller guarantees no push when full and no pop when empty.
module d_queue_store #(
    parameter int DEPTH = 4,
    parameter int W     = 146,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] head, tail;

    // Storage contents are never reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[tail] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + AW'(1);
            if (pop)  head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[head];

endmodule

// File: rtl/d_queue.sv
// Fetch-to-decode packet queue: buffers fetch packets in a small FIFO and
// presents one registered packet per cycle to decode, with stall/bubble control.
module d_queue
    import y86_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int VALW  = 64,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            f_valid,
    input  logic [1:0]      f_stat,
    input  logic [3:0]      f_icode,
    input  logic [3:0]      f_ifun,
    input  logic [3:0]      f_rA,
    input  logic [3:0]      f_rB,
    input  logic [VALW-1:0] f_valC,
    input  logic [VALW-1:0] f_valP,
    input  logic            D_stall,
    input  logic            D_bubble,
    output logic            f_full,
    output logic [1:0]      D_stat,
    output logic [3:0]      D_icode,
    output logic [3:0]      D_ifun,
    output logic [3:0]      D_rA,
    output logic [3:0]      D_rB,
    output logic [VALW-1:0] D_valC,
    output logic [VALW-1:0] D_valP,
    output logic            D_valid,
    output logic [CW-1:0]   q_count
);

    localparam int W = $bits(d_ctrl_t) + 2 * VALW;

    logic            halt_lock;
    logic            accept, is_err, advance, empty, push, pop;
    d_ctrl_t         in_ctrl, hd_ctrl, d_ctrl;
    logic [VALW-1:0] in_valC, in_valP, hd_valC, hd_valP;
    logic [W-1:0]    rdata;

    assign f_full  = (q_count == CW'(DEPTH)) || halt_lock;
    assign accept  = f_valid && !f_full && !D_bubble;
    assign is_err  = (f_stat != SAOK);
    assign advance = !D_bubble && !D_stall;
    assign empty   = (q_count == '0);

    // An errored fetch is reduced to a halt packet carrying its status.
    always_comb begin
        in_ctrl = '{stat: f_stat, icode: f_icode, ifun: f_ifun, rA: f_rA, rB: f_rB};
        in_valC = f_valC;
        in_valP = f_valP;
        if (is_err) begin
            in_ctrl = halt_ctrl(f_stat);
            in_valC = '0;
            in_valP = '0;
        end
    end

    // An empty queue on an advancing cycle bypasses straight into D_*.
    assign push = accept && !(advance && empty);
    assign pop  = advance && !empty;

    d_queue_store #(.DEPTH(DEPTH), .W(W)) u_store (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (D_bubble),
        .push  (push),
        .pop   (pop),
        .wdata ({in_ctrl, in_valC, in_valP}),
        .rdata (rdata),
        .count (q_count)
    );

    assign {hd_ctrl, hd_valC, hd_valP} = rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_ctrl    <= BUBBLE_CTRL;
            D_valC    <= '0;
            D_valP    <= '0;
            D_valid   <= 1'b0;
            halt_lock <= 1'b0;
        end else if (D_bubble) begin
            d_ctrl    <= BUBBLE_CTRL;
            D_valC    <= '0;
            D_valP    <= '0;
            D_valid   <= 1'b0;
            halt_lock <= 1'b0;
        end else begin
            if (accept && is_err) halt_lock <= 1'b1;
            if (!D_stall) begin
                if (!empty) begin
                    d_ctrl  <= hd_ctrl;
                    D_valC  <= hd_valC;
                    D_valP  <= hd_valP;
                    D_valid <= 1'b1;
                end else if (accept) begin
                    d_ctrl  <= in_ctrl;
                    D_valC  <= in_valC;
                    D_valP  <= in_valP;
                    D_valid <= 1'b1;
                end else begin
                    d_ctrl  <= BUBBLE_CTRL;
                    D_valC  <= '0;
                    D_valP  <= '0;
                    D_valid <= 1'b0;
                end
            end
        end
    end

    assign D_stat  = d_ctrl.stat;
    assign D_icode = d_ctrl.icode;
    assign D_ifun  = d_ctrl.ifun;
    assign D_rA    = d_ctrl.rA;
    assign D_rB    = d_ctrl.rB;

endmodule

// File: tb/tb_d_queue.sv
// Directed bench for d_queue: a vector table of single-cycle steps, then
// hand-written wrap-around and asynchronous-reset sequences.
module tb_d_queue;

    localparam int DEPTH = 4;
    localparam int VALW  = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            f_valid = 1'b0;
    logic [1:0]      f_stat = '0;
    logic [3:0]      f_icode = '0, f_ifun = '0, f_rA = '0, f_rB = '0;
    logic [VALW-1:0] f_valC = '0, f_valP = '0;
    logic            D_stall = 1'b0, D_bubble = 1'b0;
    logic            f_full;
    logic [1:0]      D_stat;
    logic [3:0]      D_icode, D_ifun, D_rA, D_rB;
    logic [VALW-1:0] D_valC, D_valP;
    logic            D_valid;
    logic [CW-1:0]   q_count;

    int tests = 0;
    int fails = 0;

    d_queue #(.DEPTH(DEPTH), .VALW(VALW)) dut (
        .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_stat(f_stat),
        .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
        .f_valC(f_valC), .f_valP(f_valP), .D_stall(D_stall), .D_bubble(D_bubble),
        .f_full(f_full), .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun),
        .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP),
        .D_valid(D_valid), .q_count(q_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] st;
        logic [3:0] ic;
        logic       stall;
        logic       bub;
        logic [1:0] e_stat;
        logic [3:0] e_ic;
        logic [3:0] e_ra;
        logic       e_valid;
        int         e_cnt;
        logic       e_full;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic v, logic [1:0] st, logic [3:0] ic, logic stall, logic bub,
                                logic [1:0] e_stat, logic [3:0] e_ic, logic [3:0] e_ra,
                                logic e_valid, int e_cnt, logic e_full);
        vec_t t;
        t = '{v, st, ic, stall, bub, e_stat, e_ic, e_ra, e_valid, e_cnt, e_full};
        vq.push_back(t);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle past the edge.
    task automatic step(input logic v, input logic [1:0] st, input logic [3:0] ic,
                        input logic [VALW-1:0] vc, input logic [VALW-1:0] vp,
                        input logic stall, input logic bub);
        f_valid = v; f_stat = st; f_icode = ic; f_ifun = 4'h0;
        f_rA = ic; f_rB = ~ic; f_valC = vc; f_valP = vp;
        D_stall = stall; D_bubble = bub;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Rows: v st ic stall bub | stat icode rA valid count full
        add(1, 0, 6, 0, 0,  0, 6, 6, 1, 0, 0); // bypass
        add(0, 0, 0, 0, 0,  0, 1, 4'hF, 0, 0, 0); // empty -> bubble
        add(1, 0, 9, 0, 0,  0, 9, 9, 1, 0, 0);
        add(1, 0, 2, 1, 0,  0, 9, 9, 1, 1, 0); // stall, fill P1..P4
        add(1, 0, 3, 1, 0,  0, 9, 9, 1, 2, 0);
        add(1, 0, 4, 1, 0,  0, 9, 9, 1, 3, 0);
        add(1, 0, 5, 1, 0,  0, 9, 9, 1, 4, 1);
        add(1, 0, 7, 1, 0,  0, 9, 9, 1, 4, 1); // P5, P6 refused
        add(1, 0, 8, 1, 0,  0, 9, 9, 1, 4, 1);
        add(0, 0, 0, 0, 0,  0, 2, 2, 1, 3, 0); // drain in order
        add(0, 0, 0, 0, 0,  0, 3, 3, 1, 2, 0);
        add(0, 0, 0, 0, 0,  0, 4, 4, 1, 1, 0);
        add(0, 0, 0, 0, 0,  0, 5, 5, 1, 0, 0);
        add(0, 0, 0, 0, 0,  0, 1, 4'hF, 0, 0, 0);
        add(1, 0, 6, 1, 0,  0, 1, 4'hF, 0, 1, 0);
        add(1, 2, 7, 1, 0,  0, 1, 4'hF, 0, 2, 1); // error packet locks
        add(1, 0, 3, 0, 0,  0, 6, 6, 1, 1, 1);
        add(1, 0, 3, 0, 0,  2, 0, 4'hF, 1, 0, 1); // converted halt
        add(1, 0, 3, 0, 0,  0, 1, 4'hF, 0, 0, 1); // still locked
        add(1, 0, 5, 0, 1,  0, 1, 4'hF, 0, 0, 0); // bubble unlocks
        add(1, 0, 2, 1, 0,  0, 1, 4'hF, 0, 1, 0);
        add(1, 0, 3, 1, 0,  0, 1, 4'hF, 0, 2, 0);
        add(1, 0, 4, 1, 0,  0, 1, 4'hF, 0, 3, 0);
        add(1, 0, 5, 1, 1,  0, 1, 4'hF, 0, 0, 0); // bubble beats stall, drops offer
        add(0, 0, 0, 0, 0,  0, 1, 4'hF, 0, 0, 0);

        #12;
        check("rst_icode", D_icode, 1);
        check("rst_rA", D_rA, 4'hF);
        check("rst_valid", D_valid, 0);
        check("rst_count", q_count, 0);
        check("rst_full", f_full, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            step(vq[i].v, vq[i].st, vq[i].ic, 64'(vq[i].ic), 64'(vq[i].ic) + 1, vq[i].stall, vq[i].bub);
            check($sformatf("v%0d_stat", i), D_stat, vq[i].e_stat);
            check($sformatf("v%0d_icode", i), D_icode, vq[i].e_ic);
            check($sformatf("v%0d_rA", i), D_rA, vq[i].e_ra);
            check($sformatf("v%0d_valid", i), D_valid, vq[i].e_valid);
            check($sformatf("v%0d_count", i), q_count, 64'(vq[i].e_cnt));
            check($sformatf("v%0d_full", i), f_full, vq[i].e_full);
        end

        // Steady push/pop with two entries resident, wrapping the pointers.
        step(1, 0, 0, 64'hC000, 64'hA000, 1, 0);
        step(1, 0, 1, 64'hC001, 64'hA001, 1, 0);
        check("wrap_prime", q_count, 2);
        for (int k = 2; k < 12; k++) begin
            step(1, 0, 4'(k), 64'hC000 + 64'(k), 64'hA000 + 64'(k), 0, 0);
            check($sformatf("wrap%0d_icode", k), D_icode, 64'(k - 2));
            check($sformatf("wrap%0d_valC", k), D_valC, 64'hC000 + 64'(k - 2));
            check($sformatf("wrap%0d_valP", k), D_valP, 64'hA000 + 64'(k - 2));
            check($sformatf("wrap%0d_count", k), q_count, 2);
        end
        for (int k = 10; k < 12; k++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            check($sformatf("tail%0d_icode", k), D_icode, 64'(k));
            check($sformatf("tail%0d_count", k), q_count, 64'(11 - k));
        end

        // Fill the queue, then drop reset between clock edges.
        for (int k = 1; k <= 4; k++) step(1, 0, 4'(k), 64'(k), 64'(k), 1, 0);
        check("pre_rst_count", q_count, 4);
        check("pre_rst_full", f_full, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_count", q_count, 0);
        check("arst_full", f_full, 0);
        check("arst_icode", D_icode, 1);
        check("arst_rA", D_rA, 4'hF);
        check("arst_valid", D_valid, 0);
        check("arst_valC", D_valC, 0);
        #2 rst_n = 1'b1;
        step(1, 0, 6, 64'h66, 64'h67, 0, 0);
        check("post_rst_icode", D_icode, 6);
        check("post_rst_valC", D_valC, 64'h66);
        check("post_rst_valid", D_valid, 1);
        check("post_rst_count", q_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/d_queue.md
D_QUEUE -- requirements
Module: d_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queued fetch packets (power of 2, >=2).
REQ-002 SHALL have parameter VALW, default 64, width of valC/valP.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port f_valid  in  1  fetch offers a packet this cycle.
REQ-006 SHALL have port f_stat  in  2  fetch status (0 = AOK).
REQ-007 SHALL have port f_icode  in  4  instruction code.
REQ-008 SHALL have port f_ifun  in  4  function code.
REQ-009 SHALL have port f_rA  in  4  register A id.
REQ-010 SHALL have port f_rB  in  4  register B id.
REQ-011 SHALL have port f_valC  in  VALW  constant word.
REQ-012 SHALL have port f_valP  in  VALW  next PC.
REQ-013 SHALL have port D_stall  in  1  hold decode outputs.
REQ-014 SHALL have port D_bubble  in  1  flush queue, inject nop.
REQ-015 SHALL have port f_full  out  1  fetch must stall; packet not accepted.
REQ-016 SHALL have ports D_stat/D_icode/D_ifun/D_rA/D_rB  out  2/4/4/4/4  decode-stage packet.
REQ-017 SHALL have ports D_valC/D_valP  out  VALW  decode-stage words.
REQ-018 SHALL have port D_valid  out  1  D_* holds a real (non-bubble) packet.
REQ-019 SHALL have port q_count  out  clog2(DEPTH)+1  occupied entries.

Function
REQ-020 SHALL store packets in a DEPTH-entry circular FIFO; head/tail pointers wrap mod DEPTH; D_* is a separate output register.
REQ-021 SHALL assert f_full combinationally when q_count==DEPTH or halt_lock==1.
REQ-022 SHALL accept (enqueue) when f_valid && !f_full && !D_bubble.
REQ-023 SHALL convert an accepted packet with f_stat!=0 to {stat=f_stat, icode 0, ifun 0, rA F, rB F, valC 0, valP 0} and set halt_lock.
REQ-024 SHALL keep halt_lock set, refusing all packets, until D_bubble or reset.
REQ-025 Bubble value SHALL be {stat 0, icode 1, ifun 0, rA F, rB F, valC 0, valP 0} with D_valid=0.
REQ-026 SHALL apply edge priority D_bubble > D_stall > advance.
REQ-027 D_bubble SHALL zero q_count and pointers, clear halt_lock, load bubble into D_*, and drop any same-cycle offered packet.
REQ-028 D_stall (no bubble) SHALL hold all D_* and D_valid and pop nothing; enqueue continues if not full.
REQ-029 Advance with q_count>0 SHALL load head into D_*, D_valid=1, pop; a simultaneous enqueue writes tail (count unchanged).
REQ-030 Advance with q_count==0 and an accepted packet SHALL bypass it straight into D_* (1-cycle latency), nothing stored.
REQ-031 Advance with q_count==0 and no accepted packet SHALL load bubble.
REQ-032 SHALL preserve strict FIFO order across stall, wrap-around and bypass.

Reset
REQ-033 rst_n low SHALL immediately force q_count 0, pointers 0, halt_lock 0, D_* to bubble, D_valid 0.
REQ-034 First posedge after rst_n rises SHALL operate normally; storage-array contents need no reset.

Structure
REQ-035 Shared package y86_pkg SHALL hold stat codes (SAOK=0), ICODE_HALT=0, ICODE_NOP=1, RNONE=4'hF and the decode-packet typedef.
REQ-036 Circular storage SHALL be sub-module d_queue_store (array, pointers, count); d_queue holds control, halt_lock and the output register.

Verification
REQ-037 Reset then icode 6 valid one cycle, no stall -> next edge D_icode=6, D_valid=1, q_count=0 (bypass).
REQ-038 D_stall high 6 cycles, DEPTH=4, packets P1..P6 offered -> f_full rises after 4 accepted, q_count=4, D_* unchanged; release -> P1..P4 emerge in order.
REQ-039 f_stat=2 packet mid-stream -> D_stat=2, D_icode=0 in order, f_full=1 thereafter; later valid packets ignored.
REQ-040 Queue holding 3, D_bubble and D_stall both high with f_valid -> q_count=0, D_icode=1, D_rA=F, D_valid=0, halt_lock 0, offered packet lost.
REQ-041 Continuous push/pop 10 packets across pointer wrap -> output order matches input, q_count constant.
REQ-042 rst_n low asynchronously mid-cycle with queue full -> outputs bubble before next clock edge, q_count=0, f_full=0.
